// File: rtl/tff_counter_param.sv
// rtl/tff_counter_param.sv - parameterised modulo counter with prescaler, load, wrap pulse and sticky overflow
//
// Parameters:
//   WIDTH        counter width in bits
//   MODULUS      count range 0..MODULUS-1 (2..2^WIDTH)
//   PRESCALE_DIV enabled clocks per count step (1..65535)
//
// Ports:
//   clock       rising-edge clock
//   resetb      asynchronous reset, active-high
//   enable      count enable, gates the prescaler
//   up          direction: 1 = increment, 0 = decrement
//   load        synchronous load strobe (beats a step on the same edge)
//   load_value  value loaded when load=1, clamped to MODULUS-1
//   ovf_clr     synchronous clear of the sticky ovf flag
//   Q           registered count value
//   tick        combinational: a count step happens on the next edge
//   wrap        registered one-cycle pulse after a boundary crossing
//   ovf         registered sticky overflow/underflow flag
//
// Build option:
//   TFF_COUNTER_SATURATE_EN  when defined, a step at the boundary holds Q
//                            (still pulsing wrap and setting ovf) instead of wrapping.

module tff_counter_param #(
    parameter int WIDTH        = 8,
    parameter int MODULUS      = 256,
    parameter int PRESCALE_DIV = 1
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic             enable,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] Q,
    output logic             tick,
    output logic             wrap,
    output logic             ovf
);

    localparam int               PS_W    = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam logic [PS_W-1:0]  PS_LAST = PS_W'(PRESCALE_DIV - 1);
    localparam logic [WIDTH-1:0] Q_MAX   = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2^WIDTH is representable for the clamp compare.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_q, q_d;
    logic [PS_W-1:0]  ps_q, ps_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             step;

    always_comb begin
        step   = enable & (ps_q == PS_LAST);
        // Flops are held at zero during reset, but tick is combinational
        // and must be masked explicitly.
        tick   = step & ~resetb;

        q_d    = q_q;
        ps_d   = ps_q;
        wrap_d = 1'b0;

        if (load) begin
            q_d  = ({1'b0, load_value} >= MOD_EXT) ? Q_MAX : load_value;
            ps_d = '0;
        end else if (step) begin
            ps_d = '0;
            if (up) begin
                if (q_q == Q_MAX) begin
`ifdef TFF_COUNTER_SATURATE_EN
                    q_d = q_q;
`else
                    q_d = '0;
`endif
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + 1'b1;
                end
            end else begin
                if (q_q == '0) begin
`ifdef TFF_COUNTER_SATURATE_EN
                    q_d = q_q;
`else
                    q_d = Q_MAX;
`endif
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q - 1'b1;
                end
            end
        end else if (enable) begin
            ps_d = ps_q + 1'b1;
        end

        // A new boundary event overrides a simultaneous clear.
        ovf_d = wrap_d | (ovf_q & ~ovf_clr);
    end

    always_ff @(posedge clock or posedge resetb) begin
        if (resetb) begin
            q_q    <= '0;
            ps_q   <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            ps_q   <= ps_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign Q    = q_q;
    assign wrap = wrap_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_tff_counter_param.sv
// tb/tb_tff_counter_param.sv - directed self-checking bench for tff_counter_param

module tb_tff_counter_param;

    logic       clock = 1'b0;
    logic       rst;
    logic       enable;
    logic       up;
    logic       load;
    logic [7:0] load_value;
    logic       ovf_clr;

    logic [7:0] q_a, q_b, q_c;
    logic       tick_a, tick_b, tick_c;
    logic       wrap_a, wrap_b, wrap_c;
    logic       ovf_a, ovf_b, ovf_c;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    // Full 8-bit binary counter, no prescale.
    tff_counter_param #(.WIDTH(8), .MODULUS(256), .PRESCALE_DIV(1)) u_a (
        .clock(clock), .resetb(rst), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .ovf_clr(ovf_clr),
        .Q(q_a), .tick(tick_a), .wrap(wrap_a), .ovf(ovf_a)
    );

    // Decade counter, no prescale.
    tff_counter_param #(.WIDTH(8), .MODULUS(10), .PRESCALE_DIV(1)) u_b (
        .clock(clock), .resetb(rst), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .ovf_clr(ovf_clr),
        .Q(q_b), .tick(tick_b), .wrap(wrap_b), .ovf(ovf_b)
    );

    // Decade counter, divide-by-4 prescale.
    tff_counter_param #(.WIDTH(8), .MODULUS(10), .PRESCALE_DIV(4)) u_c (
        .clock(clock), .resetb(rst), .enable(enable), .up(up), .load(load),
        .load_value(load_value), .ovf_clr(ovf_clr),
        .Q(q_c), .tick(tick_c), .wrap(wrap_c), .ovf(ovf_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; up = 1'b1; load = 1'b0; load_value = 8'h00; ovf_clr = 1'b0;

        // Reset state; tick must be masked even with enable high.
        step();
        step();
        check("rst_q", q_a, 0);
        check("rst_wrap", wrap_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_tick", tick_a, 0);
        check("rst_tick_c", tick_c, 0);

        // Asynchronous reset mid-count.
        rst = 1'b0; enable = 1'b0; load = 1'b1; load_value = 8'h37;
        step();
        check("ld37_q", q_a, 8'h37);
        check("ld37_clamp_b", q_b, 9);
        load = 1'b0; enable = 1'b1;
        #1;
        check("ld37_tick", tick_a, 1);
        rst = 1'b1;
        #1;
        check("arst_q", q_a, 0);
        check("arst_wrap", wrap_a, 0);
        check("arst_ovf", ovf_a, 0);
        check("arst_tick", tick_a, 0);
        rst = 1'b0; enable = 1'b0;

        // Up-count wrap, MODULUS=10.
        load = 1'b1; load_value = 8'd8;
        step();
        check("up_q8", q_b, 8);
        load = 1'b0; enable = 1'b1; up = 1'b1;
        step();
        check("up_q9", q_b, 9);
        check("up_wrap9", wrap_b, 0);
        step();
        check("up_q0", q_b, 0);
        check("up_wrap0", wrap_b, 1);
        check("up_ovf0", ovf_b, 1);
        step();
        check("up_q1", q_b, 1);
        check("up_wrap1", wrap_b, 0);
        check("up_ovf1", ovf_b, 1);
        enable = 1'b0; ovf_clr = 1'b1;
        step();
        check("up_ovfclr", ovf_b, 0);
        ovf_clr = 1'b0;

        // Down-count wrap; clear on the wrapping edge loses to the set.
        load = 1'b1; load_value = 8'd1;
        step();
        check("dn_q1", q_b, 1);
        load = 1'b0; enable = 1'b1; up = 1'b0;
        step();
        check("dn_q0", q_b, 0);
        check("dn_wrap0", wrap_b, 0);
        ovf_clr = 1'b1;
        step();
        check("dn_q9", q_b, 9);
        check("dn_wrap9", wrap_b, 1);
        check("dn_ovf_setwins", ovf_b, 1);
        ovf_clr = 1'b0;
        step();
        check("dn_q8", q_b, 8);
        check("dn_wrap8", wrap_b, 0);
        check("dn_ovf8", ovf_b, 1);
        enable = 1'b0;

        // Prescaler divide-by-4, with enable dropped mid-period.
        load = 1'b1; load_value = 8'd0;
        step();
        check("ps_q0", q_c, 0);
        load = 1'b0; enable = 1'b1; up = 1'b1;
        #1;
        check("ps_tick_p0", tick_c, 0);
        step();
        step();
        check("ps_tick_p2", tick_c, 0);
        step();
        check("ps_tick_p3", tick_c, 1);
        check("ps_q_p3", q_c, 0);
        step();
        check("ps_q1", q_c, 1);
        check("ps_tick_after", tick_c, 0);
        step();
        step();
        enable = 1'b0;
        step();
        step();
        step();
        check("ps_hold_q", q_c, 1);
        check("ps_hold_tick", tick_c, 0);
        enable = 1'b1;
        step();
        check("ps_resume_tick", tick_c, 1);
        check("ps_resume_q", q_c, 1);
        step();
        check("ps_q2", q_c, 2);

        // Load with clamp beats a simultaneous step; prescaler restarts.
        step();
        step();
        step();
        check("lp_tick_c", tick_c, 1);
        load = 1'b1; load_value = 8'd15; ovf_clr = 1'b1;
        #1;
        check("lp_tick_b", tick_b, 1);
        step();
        check("lp_q_b", q_b, 9);
        check("lp_wrap_b", wrap_b, 0);
        check("lp_ovf_b", ovf_b, 0);
        check("lp_q_c", q_c, 9);
        check("lp_wrap_c", wrap_c, 0);
        load = 1'b0; ovf_clr = 1'b0;
        #1;
        check("lp_ps_zero", tick_c, 0);

        // Three steps from the top boundary.
`ifdef TFF_COUNTER_SATURATE_EN
        step();
        check("sat_q_1", q_b, 9);
        check("sat_wrap_1", wrap_b, 1);
        check("sat_ovf_1", ovf_b, 1);
        step();
        check("sat_q_2", q_b, 9);
        check("sat_wrap_2", wrap_b, 1);
        step();
        check("sat_q_3", q_b, 9);
        check("sat_wrap_3", wrap_b, 1);
        check("sat_ovf_3", ovf_b, 1);
`else
        step();
        check("mod_q_1", q_b, 0);
        check("mod_wrap_1", wrap_b, 1);
        check("mod_ovf_1", ovf_b, 1);
        step();
        check("mod_q_2", q_b, 1);
        check("mod_wrap_2", wrap_b, 0);
        step();
        check("mod_q_3", q_b, 2);
        check("mod_wrap_3", wrap_b, 0);
        check("mod_ovf_3", ovf_b, 1);
`endif
        check("c_no_step", q_c, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
